// File: rtl/frame_sched_pkg.sv
// Shared types and default geometry for the DDR frame delayer command scheduler.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_AR
    } state_e;

    localparam int unsigned DEF_H_WIDTH   = 1920;
    localparam int unsigned DEF_V_HEIGHT  = 1080;
    localparam int unsigned DEF_BURST_LEN = 16;
    localparam int unsigned BURST_BYTES   = DEF_BURST_LEN * 4;
    localparam int unsigned NBURST        = DEF_H_WIDTH * DEF_V_HEIGHT / DEF_BURST_LEN;
    localparam int unsigned FRAME_BYTES   = DEF_H_WIDTH * DEF_V_HEIGHT * 4;

    function automatic logic [31:0] burst_addr(
        input logic [31:0] base,
        input logic        sel,
        input logic [31:0] frame_bytes,
        input logic [31:0] idx,
        input logic [31:0] burst_bytes
    );
        return base + (sel ? frame_bytes : 32'd0) + idx * burst_bytes;
    endfunction

endpackage

// File: rtl/axi_frame_scheduler_burst_ctr.sv
// Per-frame burst counter: saturates at LIMIT, synchronous clear has priority.
module burst_ctr #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign full_o = (cnt_q == W'(LIMIT));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_frame_scheduler.sv
// AXI3 command scheduler sharing one master port between frame capture and playback,
// with double-buffered frame bases swapped on vsync.
module axi_frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned H_WIDTH   = DEF_H_WIDTH,
    parameter int unsigned V_HEIGHT  = DEF_V_HEIGHT,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vs_i,
    input  logic        wen_i,
    input  logic        wr_req_i,
    output logic        wr_ack_o,
    input  logic        rd_req_i,
    output logic        rd_ack_o,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [3:0]  m_axi_awlen,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [3:0]  m_axi_arlen,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        rdone_i,
    output logic        err_o,
    output logic        drop_o
);

    localparam int unsigned N_BURST = H_WIDTH * V_HEIGHT / BURST_LEN;
    localparam int unsigned F_BYTES = H_WIDTH * V_HEIGHT * 4;
    localparam int unsigned B_BYTES = BURST_LEN * 4;
    localparam int unsigned CW      = $clog2(N_BURST + 1);

    state_e      state_q;
    logic        vs_q, wr_buf_q, rd_buf_q, rd_valid_q;
    logic        last_rd_q, stale_q, err_q, drop_q;
    logic        awvalid_q, arvalid_q;
    logic [31:0] awaddr_q, araddr_q;
    logic [3:0]  wout_q, wout_d, rout_q, rout_d;
    logic [CW-1:0] wcnt, rcnt;
    logic        wfull, rfull;
    logic        vs_edge, aw_hs, ar_hs, b_fire, b_dec, r_dec;
    logic        wr_ok, rd_ok, grant_rd, grant_wr;

    assign vs_edge  = vs_i & ~vs_q;
    assign aw_hs    = awvalid_q & m_axi_awready;
    assign ar_hs    = arvalid_q & m_axi_arready;
    assign b_fire   = m_axi_bvalid & m_axi_bready;
    assign b_dec    = b_fire & (wout_q != 4'd0);
    assign r_dec    = rdone_i & (rout_q != 4'd0);
    assign wr_ok    = wr_req_i & wen_i & ~wfull & (wout_q < 4'(MAX_OUTST));
    assign rd_ok    = rd_req_i & rd_valid_q & ~rfull & (rout_q < 4'(MAX_OUTST));
    // Read wins unless the previous grant was also a read and a write waits.
    assign grant_rd = rd_ok & (~wr_ok | ~last_rd_q);
    assign grant_wr = wr_ok & ~grant_rd;

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 4'(BURST_LEN - 1);
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 4'(BURST_LEN - 1);
    assign m_axi_bready  = ~rst_i;
    assign wr_ack_o      = aw_hs;
    assign rd_ack_o      = ar_hs;
    assign err_o         = err_q;
    assign drop_o        = drop_q;

    // A command granted before a vsync edge belongs to the old frame and is not counted.
    burst_ctr #(.LIMIT(N_BURST), .W(CW)) u_wcnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (vs_edge),
        .en_i  (aw_hs & ~stale_q),
        .cnt_o (wcnt),
        .full_o(wfull)
    );

    burst_ctr #(.LIMIT(N_BURST), .W(CW)) u_rcnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (vs_edge),
        .en_i  (ar_hs & ~stale_q),
        .cnt_o (rcnt),
        .full_o(rfull)
    );

    always_comb begin
        wout_d = wout_q;
        rout_d = rout_q;
        if (aw_hs && !b_dec) wout_d = wout_q + 4'd1;
        else if (!aw_hs && b_dec) wout_d = wout_q - 4'd1;
        if (ar_hs && !r_dec) rout_d = rout_q + 4'd1;
        else if (!ar_hs && r_dec) rout_d = rout_q - 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            vs_q       <= 1'b0;
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            last_rd_q  <= 1'b0;
            stale_q    <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            awvalid_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wout_q     <= '0;
            rout_q     <= '0;
        end else begin
            vs_q   <= vs_i;
            wout_q <= wout_d;
            rout_q <= rout_d;
            drop_q <= 1'b0;
            if (b_fire && m_axi_bresp != 2'b00) err_q <= 1'b1;
            if (vs_edge && wen_i) begin
                if (wfull && wout_q == 4'd0) begin
                    rd_buf_q   <= wr_buf_q;
                    wr_buf_q   <= ~wr_buf_q;
                    rd_valid_q <= 1'b1;
                end else begin
                    drop_q <= 1'b1;
                end
            end
            unique case (state_q)
                S_IDLE: begin
                    stale_q <= vs_edge;
                    if (grant_rd) begin
                        araddr_q  <= burst_addr(BASE_ADDR, rd_buf_q, 32'(F_BYTES),
                                                32'(rcnt), 32'(B_BYTES));
                        arvalid_q <= 1'b1;
                        last_rd_q <= 1'b1;
                        state_q   <= S_AR;
                    end else if (grant_wr) begin
                        awaddr_q  <= burst_addr(BASE_ADDR, wr_buf_q, 32'(F_BYTES),
                                                32'(wcnt), 32'(B_BYTES));
                        awvalid_q <= 1'b1;
                        last_rd_q <= 1'b0;
                        state_q   <= S_AW;
                    end
                end
                S_AW: begin
                    if (vs_edge) stale_q <= 1'b1;
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                S_AR: begin
                    if (vs_edge) stale_q <= 1'b1;
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Responses with nothing outstanding indicate a broken data mover or interconnect.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(b_fire && wout_q == 4'd0));
            assert (!(rdone_i && rout_q == 4'd0));
        end
    end

endmodule

// File: tb/tb_axi_frame_scheduler.sv
// Directed and randomized bench for axi_frame_scheduler with a transaction-level frame model.
module tb_axi_frame_scheduler;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int HW = 64;
    localparam int VH = 4;
    localparam int BL = 16;
    localparam int MO = 4;
    localparam int NB = HW * VH / BL;
    localparam int FB = HW * VH * 4;
    localparam int BB = BL * 4;

    logic        clk = 1'b0;
    logic        rst_i, vs_i, wen_i, wr_req_i, rd_req_i;
    logic        awready, arready, bvalid, rdone;
    logic [1:0]  bresp;
    logic        wr_ack, rd_ack, awvalid, arvalid, bready, err_o, drop_o;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awlen, arlen;

    always #5 clk = ~clk;

    axi_frame_scheduler #(
        .BASE_ADDR(BASE), .H_WIDTH(HW), .V_HEIGHT(VH),
        .BURST_LEN(BL), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .vs_i(vs_i), .wen_i(wen_i),
        .wr_req_i(wr_req_i), .wr_ack_o(wr_ack),
        .rd_req_i(rd_req_i), .rd_ack_o(rd_ack),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .rdone_i(rdone), .err_o(err_o), .drop_o(drop_o)
    );

    int errors = 0;
    int checks = 0;
    int wcnt_m, rcnt_m, wout_m, rout_m;
    bit wbuf_m, rbuf_m, rdv_m, err_m;
    int aw_n, ar_n, wack_n;
    bit order_q[$];
    logic [31:0] aw_log[$];
    logic [31:0] ar_log[$];
    logic pa_aw, pa_ar;
    logic [31:0] pa_awaddr, pa_araddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fa(input bit sel, input int idx);
        return BASE + (sel ? 32'(FB) : 32'd0) + 32'(idx * BB);
    endfunction

    task automatic mreset();
        wcnt_m = 0; rcnt_m = 0; wout_m = 0; rout_m = 0;
        wbuf_m = 0; rbuf_m = 0; rdv_m = 0; err_m = 0;
        pa_aw = 0; pa_ar = 0;
    endtask

    task automatic mon();
        logic awh, arh;
        if (rst_i) return;
        awh = awvalid & awready;
        arh = arvalid & arready;
        chk("bready", bready, 1);
        chk("err", err_o, err_m);
        chk("wr_ack", wr_ack, awh);
        chk("rd_ack", rd_ack, arh);
        if (pa_aw) begin
            chk("aw_hold", awvalid, 1);
            chk("aw_addr_hold", awaddr, pa_awaddr);
        end
        if (pa_ar) begin
            chk("ar_hold", arvalid, 1);
            chk("ar_addr_hold", araddr, pa_araddr);
        end
        if (awvalid) chk("awlen", awlen, BL - 1);
        if (arvalid) chk("arlen", arlen, BL - 1);
        if (awh) begin
            chk("awaddr", awaddr, fa(wbuf_m, wcnt_m));
            chk("aw_frame_limit", wcnt_m < NB, 1);
            chk("aw_outst_limit", wout_m < MO, 1);
            wcnt_m++; wout_m++; aw_n++;
            order_q.push_back(1'b0);
            aw_log.push_back(awaddr);
        end
        if (arh) begin
            chk("araddr", araddr, fa(rbuf_m, rcnt_m));
            chk("ar_rd_valid", rdv_m, 1);
            chk("ar_frame_limit", rcnt_m < NB, 1);
            chk("ar_outst_limit", rout_m < MO, 1);
            rcnt_m++; rout_m++; ar_n++;
            order_q.push_back(1'b1);
            ar_log.push_back(araddr);
        end
        if (bvalid) begin
            wout_m--;
            if (bresp != 2'b00) err_m = 1;
        end
        if (rdone) rout_m--;
        if (wr_ack) wack_n++;
        pa_aw = awvalid & ~awready;
        pa_awaddr = awaddr;
        pa_ar = arvalid & ~arready;
        pa_araddr = araddr;
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_drive();
        bvalid = (wout_m > 0);
        rdone  = (rout_m > 0);
        bresp  = 2'b00;
    endtask

    task automatic do_reset();
        rst_i = 1; vs_i = 0; wen_i = 0; wr_req_i = 0; rd_req_i = 0;
        awready = 0; arready = 0; bvalid = 0; rdone = 0; bresp = 0;
        repeat (3) cyc();
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_acks", {wr_ack, rd_ack}, 0);
        chk("rst_err", err_o, 0);
        chk("rst_drop", drop_o, 0);
        chk("rst_bready", bready, 0);
        rst_i = 0;
        mreset();
    endtask

    task automatic drain();
        wr_req_i = 0; rd_req_i = 0; awready = 1; arready = 1;
        repeat (10) begin
            retire_drive();
            cyc();
        end
        bvalid = 0; rdone = 0;
        chk("drain_idle", {awvalid, arvalid}, 0);
    endtask

    task automatic vsync();
        bit exp_drop;
        exp_drop = wen_i && !(wcnt_m == NB && wout_m == 0);
        vs_i = 1;
        cyc();
        if (wen_i && wcnt_m == NB && wout_m == 0) begin
            rbuf_m = wbuf_m;
            wbuf_m = ~wbuf_m;
            rdv_m  = 1;
        end
        wcnt_m = 0;
        rcnt_m = 0;
        chk("vs_drop", drop_o, exp_drop);
        vs_i = 0;
        cyc();
        chk("vs_drop_pulse", drop_o, 0);
    endtask

    initial begin
        logic [31:0] hold;
        bit wb;
        int k;
        mreset();
        aw_n = 0; ar_n = 0; wack_n = 0;
        do_reset();

        wen_i = 1; wr_req_i = 1; rd_req_i = 1; awready = 1; arready = 1;
        repeat (2 * NB + 10) begin retire_drive(); cyc(); end
        chk("t1_frame_done", wcnt_m, NB);
        chk("t1_no_ar", ar_n, 0);
        chk("t1_aw0", aw_log.size() > 1 ? aw_log[0] : 32'hx, BASE);
        chk("t1_aw1", aw_log.size() > 1 ? aw_log[1] : 32'hx, BASE + 32'h40);
        drain();
        vsync();

        order_q.delete(); aw_log.delete(); ar_log.delete();
        wr_req_i = 1; rd_req_i = 1;
        repeat (4 * NB + 10) begin retire_drive(); cyc(); end
        chk("t2_count", order_q.size() >= 4, 1);
        if (order_q.size() >= 4)
            chk("t2_order", {order_q[0], order_q[1], order_q[2], order_q[3]}, 4'b1010);
        if (ar_log.size() > 0) chk("t2_ar_base", ar_log[0], BASE);
        if (aw_log.size() > 0) chk("t2_aw_base", aw_log[0], BASE + 32'(FB));
        chk("t2_wdone", wcnt_m, NB);
        chk("t2_rdone", rcnt_m, NB);
        drain();
        vsync();

        aw_n = 0;
        wr_req_i = 1; rd_req_i = 0; awready = 1; bvalid = 0;
        repeat (20) cyc();
        chk("t3_stall", aw_n, MO);
        bvalid = 1;
        cyc();
        bvalid = 0;
        repeat (6) cyc();
        chk("t3_one_more", aw_n, MO + 1);
        drain();

        wack_n = 0; k = 0;
        wr_req_i = 1; awready = 0;
        while (!awvalid && k < 5) begin cyc(); k++; end
        chk("t4_awvalid", awvalid, 1);
        hold = awaddr;
        repeat (10) begin
            cyc();
            chk("t4_valid_stable", awvalid, 1);
            chk("t4_addr_stable", awaddr, hold);
        end
        chk("t4_no_ack", wack_n, 0);
        wr_req_i = 0; awready = 1;
        repeat (3) cyc();
        chk("t4_single_ack", wack_n, 1);
        drain();

        wb = wbuf_m;
        vsync();
        aw_log.delete();
        wr_req_i = 1;
        repeat (4) cyc();
        wr_req_i = 0;
        repeat (2) cyc();
        chk("t5_restart_addr", aw_log.size() > 0 ? aw_log[0] : 32'hx, fa(wb, 0));

        if (wout_m > 0) begin
            bvalid = 1; bresp = 2'b10;
        end
        cyc();
        bvalid = 0; bresp = 2'b00;
        chk("t6_err_set", err_o, 1);
        repeat (5) cyc();
        chk("t6_err_sticky", err_o, 1);
        do_reset();
        chk("t6_err_cleared", err_o, 0);

        for (int seg = 0; seg < 5; seg++) begin
            wen_i = ($urandom_range(0, 3) != 0);
            repeat (150) begin
                wr_req_i = 1'($urandom_range(0, 1));
                rd_req_i = 1'($urandom_range(0, 1));
                awready  = ($urandom_range(0, 3) != 0);
                arready  = ($urandom_range(0, 3) != 0);
                bvalid   = (wout_m > 0) && ($urandom_range(0, 1) == 1);
                bresp    = ($urandom_range(0, 31) == 0) ? 2'b10 : 2'b00;
                rdone    = (rout_m > 0) && ($urandom_range(0, 1) == 1);
                cyc();
            end
            drain();
            vsync();
        end

        wen_i = 1; wr_req_i = 1; rd_req_i = 1; awready = 1; arready = 1;
        repeat (4 * NB + 20) begin retire_drive(); cyc(); end
        chk("final_wdone", wcnt_m, NB);
        if (rdv_m) chk("final_rdone", rcnt_m, NB);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
